// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter and its single-port RAM:
//   state_t     FSM encoding (ST_INIT clears the array, ST_RUN arbitrates)
//   CLI0/CLI1   client index constants used for grant and response routing
//   *_DEF       default address / data widths
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

endpackage

// File: rtl/ram_1rw.sv
// ram_1rw
// Single-port synchronous RAM, 2^ADDR_W x DATA_W, registered read.
// Ports:
//   clk    clock
//   en     access enable for this cycle
//   we     1 = write wdata to addr, 0 = read addr into rdata
//   addr   access address
//   wdata  write data
//   rdata  read data, valid the cycle after a read access; holds otherwise
// Neither the array nor rdata is reset; the arbiter clears the array itself.
module ram_1rw #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-client round-robin front end for a single-port RAM. After reset the
// whole array is written with INIT_VAL, then one read or write per cycle is
// granted to one client over valid/ready.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   init_done                high once the array clear has completed
//   reqN_valid/we/addr/wdata client N access request
//   reqN_ready               grant to client N (combinational from valids)
//   rspN_valid               one-cycle pulse, read data for client N
//   rspN_rdata               read data, held until the next response to N
//
// state   | meaning
// ST_INIT | writing INIT_VAL to init_addr each cycle, no grants
// ST_RUN  | round-robin arbitration between the two clients
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_addr;
  logic              last_grant;
  logic              rd_pending;
  logic              rd_client;
  logic [DATA_W-1:0] hold0, hold1;

  logic              grant_any;
  logic              grant_idx;
  logic              xfer;
  logic              sel_we;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Grant selection: a sole requester wins; under contention the client
  // that did not win last time wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_idx = CLI0;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_grant;
    end else if (req1_valid) begin
      grant_idx = CLI1;
    end
  end

  assign xfer   = (state == ST_RUN) && grant_any;
  assign sel_we = (grant_idx == CLI1) ? req1_we : req0_we;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_INIT;
      init_addr  <= '0;
      last_grant <= CLI1;
      rd_pending <= 1'b0;
      rd_client  <= CLI0;
      hold0      <= '0;
      hold1      <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_addr <= init_addr + 1'b1;
      end
      if (xfer) begin
        last_grant <= grant_idx;
      end
      rd_pending <= xfer && !sel_we;
      rd_client  <= grant_idx;
      // Capture the RAM output during the response cycle so the client
      // keeps seeing it after ram_rdata moves on.
      if (rd_pending && (rd_client == CLI0)) begin
        hold0 <= ram_rdata;
      end
      if (rd_pending && (rd_client == CLI1)) begin
        hold1 <= ram_rdata;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (init_addr == ADDR_LAST)) begin
      state_nxt = ST_RUN;
    end
  end

  // Output / RAM drive logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (state == ST_INIT) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = init_addr;
      ram_wdata = INIT_VAL;
    end else if (grant_any) begin
      ram_en = 1'b1;
      if (grant_idx == CLI1) begin
        req1_ready = 1'b1;
        ram_we     = req1_we;
        ram_addr   = req1_addr;
        ram_wdata  = req1_wdata;
      end else begin
        req0_ready = 1'b1;
        ram_we     = req0_we;
        ram_addr   = req0_addr;
        ram_wdata  = req0_wdata;
      end
    end
  end

  assign init_done  = (state == ST_RUN);
  assign rsp0_valid = rd_pending && (rd_client == CLI0);
  assign rsp1_valid = rd_pending && (rd_client == CLI1);
  // In the response cycle the RAM register already holds the data, so it is
  // forwarded directly; afterwards the captured copy is presented.
  assign rsp0_rdata = rsp0_valid ? ram_rdata : hold0;
  assign rsp1_rdata = rsp1_valid ? ram_rdata : hold1;

  ram_1rw #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule
